common_dffram_mwmr: RTL
=======================

# common_dffram_mwmr

Parametrised DFF-based register-file RAM with multiple write ports and multiple read ports. Each write port has per-lane write masks; same-address write collisions are resolved by fixed priority. Read ports select read-first or write-first (bypass) semantics, with optional one-cycle registered outputs. It is the general storage primitive for register files, rename tables and small tag arrays, replacing fixed-port-count DFF RAMs.

## Interface
- DATA_WIDTH, 8: bits per entry.
- ADDR_WIDTH, 3: address bits; DEPTH = 2^ADDR_WIDTH entries.
- WRITE_PORTS, 2: write port count, 1..4.
- READ_PORTS, 2: read port count, 1..8.
- LANE_WIDTH, 8: mask granularity; DATA_WIDTH must be a multiple of it; LANES = DATA_WIDTH/LANE_WIDTH.
- WRITE_FIRST, 0: 0 = read-first (old data), 1 = write-first (same-cycle write data bypassed to reads).
- READ_REG, 0: 0 = combinational read; 1 = registered read, latency 1.
- RAM_RESET_VALUE, all zero: DEPTH*DATA_WIDTH flat vector; entry i at [i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- clr  in  1  synchronous flash-clear; reloads RAM_RESET_VALUE into all entries.
- wen  in  WRITE_PORTS  per-port write enable.
- waddr  in  WRITE_PORTS*ADDR_WIDTH  write addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- wmask  in  WRITE_PORTS*LANES  per-port lane enables.
- wdata  in  WRITE_PORTS*DATA_WIDTH  write data.
- ren  in  READ_PORTS  read enable; used only when READ_REG=1.
- raddr  in  READ_PORTS*ADDR_WIDTH  read addresses.
- rdata  out  READ_PORTS*DATA_WIDTH  read data.

## Operation
- Lane l of entry e is written at the clock edge when some port p has wen[p]=1, waddr[p]=e and wmask[p*LANES+l]=1.
- Lanes with mask 0 hold their value.
- Collision rule: per lane, the highest-indexed qualifying port wins. Lower ports' data is discarded for that lane only.
- Lanes from different ports merge into one entry in the same cycle.
- clr=1 (with reset=1): every entry takes RAM_RESET_VALUE at the edge. All writes that cycle are ignored.
- Output registers (READ_REG=1) still load under clr, and see the pre-clear array in read-first mode. In write-first mode they see the reset value.
- reset=0: entries take RAM_RESET_VALUE and all rdata registers clear to 0. reset has priority over clr and writes.
- Value presented by read port r:
  - Read-first: the array content at raddr[r] before the edge.
  - Write-first: the merged post-write value, i.e. array content with that cycle's winning masked lanes substituted. clr is not bypassed.
- READ_REG=0: rdata[r] is combinational from raddr and, if WRITE_FIRST, from the write inputs.
- READ_REG=1: rdata[r] loads the value above at the edge when ren[r]=1 and holds when ren[r]=0.
- Out-of-range addresses cannot occur (full decode).

## Timing
- Write-to-array latency: 1 edge.
- READ_REG=0, read-first: a write at edge N becomes visible on rdata after edge N.
- READ_REG=0, write-first: the write is visible in the same cycle, before edge N.
- READ_REG=1: rdata reflects the address presented before edge N, after edge N.
  - Read-first: excludes that cycle's write.
  - Write-first: includes that cycle's write.
- Reset values, READ_REG=1: all rdata = 0 after the reset edge.
- Reset values, READ_REG=0: rdata = RAM_RESET_VALUE entry of each raddr, combinationally.
- Reset asserted mid-write: the write is dropped and the entry holds its reset value after the edge.
- There is no back-pressure or handshake; every port is accepted every cycle.

## Test plan
- Reset, then simultaneous reads of all entries. Config: DATA_WIDTH=8, DEPTH=8, RAM_RESET_VALUE entry i = 8'h10+i. Required: read of addr 5 returns 8'h15; READ_REG=1 rdata is 0 until the first ren.
- Masked merge. Config: DATA_WIDTH=16, LANE_WIDTH=8. Same cycle: port0 writes addr 3 = 16'hAABB mask 2'b11; port1 writes addr 3 = 16'hCCDD mask 2'b10. Required: entry 3 = 16'hCCBB next cycle.
- Bypass: write addr 2 = 8'h5A while read port 0 reads addr 2 (READ_REG=0).
  - WRITE_FIRST=1: rdata = 8'h5A in the same cycle.
  - WRITE_FIRST=0: old value in that cycle, 8'h5A next cycle.
- Registered hold. Config: READ_REG=1, entry 4 = 8'h33. Read addr 4 with ren=1, then ren=0 while addr 4 is rewritten to 8'h44. Required: rdata stays 8'h33 until ren=1 again, then shows 8'h44.
- Clear versus write: clr=1 with port1 writing addr 1 = 8'hFF. Required: entry 1 = 8'h11 (reset value) afterwards and the write is lost.
- Reset mid-traffic: reset=0 in the same cycle as writes to every port. Required: all entries equal RAM_RESET_VALUE and registered rdata = 0.

Source files
------------

// File: rtl/common_dffram_mwmr.sv
// Flop-based RAM with multiple masked write ports and multiple read ports.
// Per-lane write collisions go to the highest-indexed port. Reads are read-first or write-first, and either combinational or registered.
module common_dffram_mwmr #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int WRITE_PORTS = 2,
    parameter int READ_PORTS  = 2,
    parameter int LANE_WIDTH  = 8,
    parameter int WRITE_FIRST = 0,
    parameter int READ_REG    = 0,
    parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clr,
    input  logic [WRITE_PORTS-1:0]             wen,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0]  waddr,
    input  logic [WRITE_PORTS*(DATA_WIDTH/LANE_WIDTH)-1:0] wmask,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]  wdata,
    input  logic [READ_PORTS-1:0]              ren,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]   raddr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]   rdata
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_wr [DEPTH];
    logic                  write_ok;

    // Writes only land (and are only bypassed) when neither reset nor clr is active.
    assign write_ok = reset && !clr;

    // Ascending port scan: a later (higher) port overwrites a lower one lane by lane.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_wr[e] = mem_q[e];
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (wen[p] && (waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e))) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (wmask[p*LANES + l]) begin
                            mem_wr[e][l*LANE_WIDTH +: LANE_WIDTH] =
                                wdata[p*DATA_WIDTH + l*LANE_WIDTH +: LANE_WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (!reset || clr) begin
                mem_q[e] <= RAM_RESET_VALUE[e*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                mem_q[e] <= mem_wr[e];
            end
        end
    end

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] val;

        assign addr = raddr[r*ADDR_WIDTH +: ADDR_WIDTH];

        // A registered write-first port captures what the entry will hold after a clear.
        always_comb begin
            if (WRITE_FIRST == 0) begin
                val = mem_q[addr];
            end else if ((READ_REG != 0) && clr) begin
                val = RAM_RESET_VALUE[addr*DATA_WIDTH +: DATA_WIDTH];
            end else if (write_ok) begin
                val = mem_wr[addr];
            end else begin
                val = mem_q[addr];
            end
        end

        if (READ_REG != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rdata_q <= '0;
                end else if (ren[r]) begin
                    rdata_q <= val;
                end
            end

            assign rdata[r*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
        end else begin : g_comb
            logic unused_ren;

            assign unused_ren = ren[r];
            assign rdata[r*DATA_WIDTH +: DATA_WIDTH] = val;
        end
    end

endmodule
